// File: rtl/trigger_run_ctrl_if.sv
// trigger_run_ctrl_if: bundle between the host register block, the data_trigger
// channels and trigger_run_ctrl.
//   master : host/channel side. Drives CFG_*, CMD_* and CH_TVALID, and observes
//            the broadcast config, strobes, stops and status flags.
//   slave  : trigger_run_ctrl side (the mirror image of master).
interface trigger_run_ctrl_if #(
  parameter int unsigned N_CH                 = 4,
  parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
  parameter int unsigned PRE_LEN_WIDTH        = 1,
  parameter int unsigned POST_LEN_WIDTH       = 1,
  parameter int unsigned SEL_LEN_WIDTH        = 2
);
  logic                              CFG_LOAD;
  logic signed [ADC_RESOLUTION_WIDTH:0] CFG_RISE_THR;
  logic signed [ADC_RESOLUTION_WIDTH:0] CFG_FALL_THR;
  logic [PRE_LEN_WIDTH-1:0]          CFG_PRE_LEN;
  logic [POST_LEN_WIDTH-1:0]         CFG_POST_LEN;
  logic [SEL_LEN_WIDTH-1:0]          CFG_SEL_LEN;
  logic [N_CH-1:0]                   CFG_CH_MASK;
  logic                              CMD_APPLY;
  logic                              CMD_START;
  logic                              CMD_STOP;
  logic                              CMD_CLR_ERR;
  logic [N_CH-1:0]                   CH_TVALID;

  logic signed [ADC_RESOLUTION_WIDTH:0] RISING_EDGE_THRSHOLD;
  logic signed [ADC_RESOLUTION_WIDTH:0] FALLING_EDGE_THRESHOLD;
  logic [PRE_LEN_WIDTH-1:0]          PRE_ACQUISITION_LENGTH;
  logic [POST_LEN_WIDTH-1:0]         POST_ACQUISITION_LENGTH;
  logic [SEL_LEN_WIDTH-1:0]          ADC_SELECTION_PERIOD_LENGTH;
  logic [N_CH-1:0]                   SET_CONFIG;
  logic [N_CH-1:0]                   STOP;
  logic                              RUNNING;
  logic                              BUSY;
  logic                              CONFIGURED;
  logic                              CFG_ERR;
  logic                              CMD_ERR;

  modport master (
    output CFG_LOAD, CFG_RISE_THR, CFG_FALL_THR, CFG_PRE_LEN, CFG_POST_LEN, CFG_SEL_LEN,
    output CFG_CH_MASK, CMD_APPLY, CMD_START, CMD_STOP, CMD_CLR_ERR, CH_TVALID,
    input  RISING_EDGE_THRSHOLD, FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH,
    input  POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH, SET_CONFIG, STOP,
    input  RUNNING, BUSY, CONFIGURED, CFG_ERR, CMD_ERR
  );

  modport slave (
    input  CFG_LOAD, CFG_RISE_THR, CFG_FALL_THR, CFG_PRE_LEN, CFG_POST_LEN, CFG_SEL_LEN,
    input  CFG_CH_MASK, CMD_APPLY, CMD_START, CMD_STOP, CMD_CLR_ERR, CH_TVALID,
    output RISING_EDGE_THRSHOLD, FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH,
    output POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH, SET_CONFIG, STOP,
    output RUNNING, BUSY, CONFIGURED, CFG_ERR, CMD_ERR
  );
endinterface

// File: rtl/trigger_run_ctrl.sv
// trigger_run_ctrl: run controller for a bank of N_CH data_trigger channels.
// Keeps a host-loaded shadow of the trigger configuration, commits it to the
// channels with a one-cycle SET_CONFIG strobe, and sequences the per-channel
// STOP lines through IDLE -> ARM -> RUN -> DRAIN.
//
// Ports:
//   ACLK, ARESET : clock and asynchronous active-high reset.
//   bus (slave)  : CFG_* / CMD_* / CH_TVALID inputs; broadcast config,
//                  SET_CONFIG, STOP and RUNNING/BUSY/CONFIGURED/CFG_ERR/CMD_ERR.
//   TIMESTAMP, RUN_START_TS, RUN_STOP_TS : only with the optional feature.
//
// Optional feature macro: TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
//   When defined, RUN_START_TS captures TIMESTAMP on the edge STOP falls and
//   RUN_STOP_TS captures it on the edge STOP rises out of RUN.
module trigger_run_ctrl #(
  parameter int unsigned N_CH                 = 4,
  parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
  parameter int unsigned PRE_LEN_WIDTH        = 1,
  parameter int unsigned POST_LEN_WIDTH       = 1,
  parameter int unsigned SEL_LEN_WIDTH        = 2,
  parameter int unsigned ARM_CYCLES           = 8,
  parameter int unsigned DRAIN_IDLE_CYCLES    = 16
`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
  ,
  parameter int unsigned TIMESTAMP_WIDTH      = 48
`endif
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
  input  logic [TIMESTAMP_WIDTH-1:0] TIMESTAMP,
  output logic [TIMESTAMP_WIDTH-1:0] RUN_START_TS,
  output logic [TIMESTAMP_WIDTH-1:0] RUN_STOP_TS,
`endif
  trigger_run_ctrl_if.slave          bus
);

  localparam int unsigned ThrW = ADC_RESOLUTION_WIDTH + 1;
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] ArmLast   = CntW'(ARM_CYCLES);
  localparam logic [CntW-1:0] DrainDone = CntW'(DRAIN_IDLE_CYCLES);

  typedef enum logic [2:0] {StIdle, StApply, StArm, StRun, StDrain} state_e;

  state_e state_q;

  // Shadow copy written by CFG_LOAD.
  logic [ThrW-1:0]           sh_rise_q, sh_fall_q;
  logic [PRE_LEN_WIDTH-1:0]  sh_pre_q;
  logic [POST_LEN_WIDTH-1:0] sh_post_q;
  logic [SEL_LEN_WIDTH-1:0]  sh_sel_q;
  logic [N_CH-1:0]           sh_mask_q;

  // Committed (channel-facing) configuration.
  logic [ThrW-1:0]           rise_q, fall_q;
  logic [PRE_LEN_WIDTH-1:0]  pre_q;
  logic [POST_LEN_WIDTH-1:0] post_q;
  logic [SEL_LEN_WIDTH-1:0]  sel_q;
  logic [N_CH-1:0]           act_mask_q;

  logic [N_CH-1:0] set_config_q, stop_q;
  logic            running_q, busy_q, configured_q;
  logic            cfg_err_q, cfg_err_d, cmd_err_q, cmd_err_d;
  logic [CntW-1:0] arm_cnt_q, drain_cnt_q, drain_cnt_d;
  logic            cfg_ok, cmd_err_set, chan_quiet;

`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
  logic [TIMESTAMP_WIDTH-1:0] run_start_ts_q, run_stop_ts_q;
  assign RUN_START_TS = run_start_ts_q;
  assign RUN_STOP_TS  = run_stop_ts_q;
`endif

  assign cfg_ok     = ($signed(bus.CFG_RISE_THR) > $signed(bus.CFG_FALL_THR)) &&
                      (bus.CFG_CH_MASK != '0);
  assign chan_quiet = ~|(bus.CH_TVALID & act_mask_q);
  assign drain_cnt_d = chan_quiet ? drain_cnt_q + CntW'(1) : '0;

  // Which commands are illegal in the current state.
  always_comb begin
    cmd_err_set = 1'b0;
    unique case (state_q)
      StIdle:  cmd_err_set = bus.CMD_START && (bus.CMD_APPLY || !configured_q);
      StArm:   cmd_err_set = bus.CMD_APPLY || bus.CMD_START;
      StRun:   cmd_err_set = bus.CMD_APPLY || bus.CMD_START;
      StDrain: cmd_err_set = bus.CMD_APPLY || bus.CMD_START || bus.CMD_STOP;
      default: cmd_err_set = 1'b0;
    endcase
  end

  // A set in the same cycle as CMD_CLR_ERR wins.
  assign cfg_err_d = (bus.CFG_LOAD && !cfg_ok) || (cfg_err_q && !bus.CMD_CLR_ERR);
  assign cmd_err_d = cmd_err_set || (cmd_err_q && !bus.CMD_CLR_ERR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= StIdle;
      sh_rise_q    <= '0;
      sh_fall_q    <= '0;
      sh_pre_q     <= '0;
      sh_post_q    <= '0;
      sh_sel_q     <= '0;
      sh_mask_q    <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      sel_q        <= '0;
      act_mask_q   <= '0;
      set_config_q <= '0;
      stop_q       <= '1;
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
      configured_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      arm_cnt_q    <= '0;
      drain_cnt_q  <= '0;
`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
      run_start_ts_q <= '0;
      run_stop_ts_q  <= '0;
`endif
    end else begin
      cfg_err_q    <= cfg_err_d;
      cmd_err_q    <= cmd_err_d;
      set_config_q <= '0;

      if (bus.CFG_LOAD && cfg_ok) begin
        sh_rise_q <= bus.CFG_RISE_THR;
        sh_fall_q <= bus.CFG_FALL_THR;
        sh_pre_q  <= bus.CFG_PRE_LEN;
        sh_post_q <= bus.CFG_POST_LEN;
        sh_sel_q  <= bus.CFG_SEL_LEN;
        sh_mask_q <= bus.CFG_CH_MASK;
      end

      unique case (state_q)
        StIdle: begin
          // The commit happens on the edge entering APPLY so SET_CONFIG is
          // high for exactly the one APPLY cycle.
          if (bus.CMD_APPLY) begin
            state_q      <= StApply;
            rise_q       <= sh_rise_q;
            fall_q       <= sh_fall_q;
            pre_q        <= sh_pre_q;
            post_q       <= sh_post_q;
            sel_q        <= sh_sel_q;
            act_mask_q   <= sh_mask_q;
            set_config_q <= sh_mask_q;
            configured_q <= 1'b1;
            busy_q       <= 1'b1;
          end else if (bus.CMD_START && configured_q) begin
            state_q   <= StArm;
            arm_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        StApply: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        StArm: begin
          if (bus.CMD_STOP) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (arm_cnt_q == ArmLast) begin
            state_q   <= StRun;
            stop_q    <= ~act_mask_q;
            running_q <= 1'b1;
            busy_q    <= 1'b0;
`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
            run_start_ts_q <= TIMESTAMP;
`endif
          end else begin
            arm_cnt_q <= arm_cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (bus.CMD_STOP) begin
            state_q     <= StDrain;
            stop_q      <= '1;
            running_q   <= 1'b0;
            busy_q      <= 1'b1;
            drain_cnt_q <= '0;
`ifdef TRIGGER_RUN_CTRL_RUN_TIMESTAMP_EN
            run_stop_ts_q <= TIMESTAMP;
`endif
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_d;
          if (drain_cnt_d == DrainDone) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.RISING_EDGE_THRSHOLD        = rise_q;
  assign bus.FALLING_EDGE_THRESHOLD      = fall_q;
  assign bus.PRE_ACQUISITION_LENGTH      = pre_q;
  assign bus.POST_ACQUISITION_LENGTH     = post_q;
  assign bus.ADC_SELECTION_PERIOD_LENGTH = sel_q;
  assign bus.SET_CONFIG                  = set_config_q;
  assign bus.STOP                        = stop_q;
  assign bus.RUNNING                     = running_q;
  assign bus.BUSY                        = busy_q;
  assign bus.CONFIGURED                  = configured_q;
  assign bus.CFG_ERR                     = cfg_err_q;
  assign bus.CMD_ERR                     = cmd_err_q;

endmodule

// File: tb/tb_trigger_run_ctrl.sv
// Testbench for trigger_run_ctrl: directed scenarios followed by random
// stimulus. A reference model predicts the outputs after every clock edge and
// queues them; an independent monitor compares the DUT against the queue.
module tb_trigger_run_ctrl;

  localparam int NCh   = 4;
  localparam int ThrW  = 13;
  localparam int Arm   = 8;
  localparam int Drain = 16;

  typedef struct packed {
    logic [ThrW-1:0] rise;
    logic [ThrW-1:0] fall;
    logic            pre;
    logic            post;
    logic [1:0]      sel;
    logic [NCh-1:0]  set_cfg;
    logic [NCh-1:0]  stop;
    logic            running;
    logic            busy;
    logic            configured;
    logic            cfg_err;
    logic            cmd_err;
  } obs_t;

  typedef struct packed {
    logic            load;
    logic [ThrW-1:0] rise;
    logic [ThrW-1:0] fall;
    logic            pre;
    logic            post;
    logic [1:0]      sel;
    logic [NCh-1:0]  mask;
    logic            apply;
    logic            start;
    logic            stop;
    logic            clr;
    logic [NCh-1:0]  tvalid;
  } stim_t;

  typedef enum int {MIdle, MApply, MArm, MRun, MDrain} mode_e;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  trigger_run_ctrl_if #(.N_CH(NCh), .ADC_RESOLUTION_WIDTH(12), .PRE_LEN_WIDTH(1),
                        .POST_LEN_WIDTH(1), .SEL_LEN_WIDTH(2)) bus ();

  trigger_run_ctrl #(.N_CH(NCh), .ADC_RESOLUTION_WIDTH(12), .PRE_LEN_WIDTH(1),
                     .POST_LEN_WIDTH(1), .SEL_LEN_WIDTH(2), .ARM_CYCLES(Arm),
                     .DRAIN_IDLE_CYCLES(Drain)) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  obs_t exp_q[$];

  // Reference model state.
  mode_e m_mode;
  int    m_edge, m_run_at, m_quiet;
  stim_t m_sh;
  logic [NCh-1:0] m_act;
  obs_t  m_out;

  function automatic obs_t sample();
    obs_t o;
    o.rise       = bus.RISING_EDGE_THRSHOLD;
    o.fall       = bus.FALLING_EDGE_THRESHOLD;
    o.pre        = bus.PRE_ACQUISITION_LENGTH;
    o.post       = bus.POST_ACQUISITION_LENGTH;
    o.sel        = bus.ADC_SELECTION_PERIOD_LENGTH;
    o.set_cfg    = bus.SET_CONFIG;
    o.stop       = bus.STOP;
    o.running    = bus.RUNNING;
    o.busy       = bus.BUSY;
    o.configured = bus.CONFIGURED;
    o.cfg_err    = bus.CFG_ERR;
    o.cmd_err    = bus.CMD_ERR;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.stop = '1;
    return o;
  endfunction

  function automatic stim_t nop(input logic [NCh-1:0] tv);
    stim_t s;
    s = '0;
    s.tvalid = tv;
    return s;
  endfunction

  function automatic stim_t load_s(input int rise, input int fall, input logic pre,
                                   input logic post, input logic [1:0] sel,
                                   input logic [NCh-1:0] mask);
    stim_t s;
    s = '0;
    s.load = 1'b1;
    s.rise = ThrW'(rise);
    s.fall = ThrW'(fall);
    s.pre  = pre;
    s.post = post;
    s.sel  = sel;
    s.mask = mask;
    return s;
  endfunction

  task automatic check_now(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle;
    m_edge = 0;
    m_run_at = 0;
    m_quiet = 0;
    m_sh = '0;
    m_act = '0;
    m_out = reset_obs();
  endtask

  // Predicts the outputs after the next rising edge given the inputs s.
  task automatic model_edge(input stim_t s);
    obs_t  o;
    stim_t old_sh;
    logic  cmd_set, cfg_set;
    o = m_out;
    o.set_cfg = '0;
    old_sh = m_sh;
    cmd_set = 1'b0;
    cfg_set = 1'b0;
    if (s.load) begin
      if ($signed(s.rise) > $signed(s.fall) && s.mask != '0) m_sh = s;
      else cfg_set = 1'b1;
    end
    case (m_mode)
      MIdle: begin
        if (s.apply) begin
          o.rise = old_sh.rise;
          o.fall = old_sh.fall;
          o.pre = old_sh.pre;
          o.post = old_sh.post;
          o.sel = old_sh.sel;
          o.set_cfg = old_sh.mask;
          o.configured = 1'b1;
          m_act = old_sh.mask;
          m_mode = MApply;
          if (s.start) cmd_set = 1'b1;
        end else if (s.start) begin
          if (m_out.configured) begin
            m_mode = MArm;
            m_run_at = m_edge + 1 + Arm;
          end else begin
            cmd_set = 1'b1;
          end
        end
      end
      MApply: m_mode = MIdle;
      MArm: begin
        if (s.apply || s.start) cmd_set = 1'b1;
        if (s.stop) m_mode = MIdle;
        else if (m_edge == m_run_at) begin
          m_mode = MRun;
          o.stop = ~m_act;
        end
      end
      MRun: begin
        if (s.apply || s.start) cmd_set = 1'b1;
        if (s.stop) begin
          o.stop = '1;
          m_mode = MDrain;
          m_quiet = 0;
        end
      end
      MDrain: begin
        if (s.apply || s.start || s.stop) cmd_set = 1'b1;
        if ((s.tvalid & m_act) == '0) m_quiet++;
        else m_quiet = 0;
        if (m_quiet == Drain) m_mode = MIdle;
      end
      default: ;
    endcase
    o.running = (m_mode == MRun);
    o.busy = (m_mode == MApply) || (m_mode == MArm) || (m_mode == MDrain);
    o.cfg_err = cfg_set | (o.cfg_err & ~s.clr);
    o.cmd_err = cmd_set | (o.cmd_err & ~s.clr);
    m_out = o;
    exp_q.push_back(o);
    m_edge++;
  endtask

  // Called at a falling edge: drive inputs, predict, wait for next falling edge.
  task automatic step(input stim_t s);
    bus.CFG_LOAD     = s.load;
    bus.CFG_RISE_THR = s.rise;
    bus.CFG_FALL_THR = s.fall;
    bus.CFG_PRE_LEN  = s.pre;
    bus.CFG_POST_LEN = s.post;
    bus.CFG_SEL_LEN  = s.sel;
    bus.CFG_CH_MASK  = s.mask;
    bus.CMD_APPLY    = s.apply;
    bus.CMD_START    = s.start;
    bus.CMD_STOP     = s.stop;
    bus.CMD_CLR_ERR  = s.clr;
    bus.CH_TVALID    = s.tvalid;
    model_edge(s);
    @(negedge aclk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(nop('0));
  endtask

  // Monitor: every edge the registered outputs are valid; compare against the
  // oldest prediction.
  initial begin
    obs_t got, want;
    int edge_no;
    edge_no = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = sample();
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL outputs edge %0d: got %h required %h", edge_no, got, want);
        end
        edge_no++;
      end
    end
  end

  initial begin
    stim_t s;
    obs_t  r;
    step_init();
    model_reset();
    #2 areset = 1'b1;
    #1 check_now("reset_state", sample(), reset_obs());
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;

    // Load, apply, start, run.
    step(load_s(1024, 512, 1'b1, 1'b1, 2'd2, 4'b0101));
    s = nop('0); s.apply = 1'b1; step(s);
    nops(3);
    s = nop('0); s.start = 1'b1; step(s);
    nops(12);

    // Stop with channel 0 still streaming; channel 1 is masked out.
    s = nop(4'b0001); s.stop = 1'b1; step(s);
    for (int i = 0; i < 5; i++) step(nop(4'b0011));
    for (int i = 0; i < 20; i++) step(nop({2'b00, i[0], 1'b0}));

    // Rejected load, re-apply, clear.
    step(load_s(500, 512, 1'b0, 1'b0, 2'd3, 4'b1111));
    s = nop('0); s.apply = 1'b1; step(s);
    nops(2);
    s = nop('0); s.clr = 1'b1; step(s);
    step(load_s(-5, -5, 1'b0, 1'b0, 2'd1, 4'b0010));
    step(load_s(7, -7, 1'b0, 1'b0, 2'd1, 4'b0000));
    nops(2);

    // Simultaneous apply and start.
    s = nop('0); s.apply = 1'b1; s.start = 1'b1; step(s);
    nops(2);
    s = nop('0); s.clr = 1'b1; step(s);

    // Start then reset asynchronously mid-run.
    s = nop('0); s.start = 1'b1; step(s);
    nops(12);
    #2 areset = 1'b1;
    #1 r = sample();
    check_now("async_reset_mid_run", r, reset_obs());
    model_reset();
    step_init();
    @(negedge aclk);
    areset = 1'b0;

    // Start before apply is an error; then an aborted ARM.
    s = nop('0); s.start = 1'b1; step(s);
    nops(2);
    step(load_s(-100, -300, 1'b0, 1'b1, 2'd1, 4'b1100));
    s = nop('0); s.apply = 1'b1; s.clr = 1'b1; step(s);
    nops(1);
    s = nop('0); s.start = 1'b1; step(s);
    nops(2);
    s = nop('0); s.stop = 1'b1; step(s);
    nops(12);
    // Commands during ARM and DRAIN.
    s = nop('0); s.start = 1'b1; step(s);
    s = nop('0); s.apply = 1'b1; s.clr = 1'b1; step(s);
    nops(10);
    s = nop('0); s.stop = 1'b1; step(s);
    s = nop('0); s.stop = 1'b1; step(s);
    nops(20);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.load  = ($urandom_range(0, 9) == 0);
      s.rise  = ThrW'($urandom);
      s.fall  = ThrW'($urandom);
      s.pre   = 1'($urandom);
      s.post  = 1'($urandom);
      s.sel   = 2'($urandom);
      s.mask  = ($urandom_range(0, 15) == 0) ? '0 : NCh'($urandom);
      if (m_mode != MApply) begin
        s.apply = ($urandom_range(0, 11) == 0);
        s.start = ($urandom_range(0, 7) == 0);
        s.stop  = ($urandom_range(0, 15) == 0);
      end
      s.clr    = ($urandom_range(0, 19) == 0);
      s.tvalid = ($urandom_range(0, 15) == 0) ? NCh'($urandom) : '0;
      step(s);
    end
    nops(2);
    @(posedge aclk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic step_init();
    bus.CFG_LOAD     = 1'b0;
    bus.CFG_RISE_THR = '0;
    bus.CFG_FALL_THR = '0;
    bus.CFG_PRE_LEN  = '0;
    bus.CFG_POST_LEN = '0;
    bus.CFG_SEL_LEN  = '0;
    bus.CFG_CH_MASK  = '0;
    bus.CMD_APPLY    = 1'b0;
    bus.CMD_START    = 1'b0;
    bus.CMD_STOP     = 1'b0;
    bus.CMD_CLR_ERR  = 1'b0;
    bus.CH_TVALID    = '0;
  endtask

endmodule
